// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC angle sequencer.
//   state_t   : sequencer FSM state encoding
//   DEG_*     : quadrant boundaries in integer degrees (11-bit angle domain)
//   ANG_W     : width of the integer-degree angle and the reduced signed angle
//   X0_GAIN   : 1/K in Q2.30, loaded as the core's initial X
//   ONE       : 1.0 in Q2.30
package cordic_pkg;

  localparam int ANG_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_CRST   = 3'd2,
    ST_LOAD   = 3'd3,
    ST_RUN    = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  localparam logic [ANG_W-1:0] DEG_90  = 11'd90;
  localparam logic [ANG_W-1:0] DEG_180 = 11'd180;
  localparam logic [ANG_W-1:0] DEG_270 = 11'd270;
  localparam logic [ANG_W-1:0] DEG_360 = 11'd360;

  localparam logic [31:0] X0_GAIN = 32'h26DD3B6A;
  localparam logic [31:0] ONE     = 32'h40000000;

endpackage

// File: rtl/cordic_angle_reduce.sv
// Angle reduction and quadrant decode for the CORDIC sequencer.
// Reduces an integer-degree angle mod 360 by repeated subtraction (one
// subtract per cycle while step is high), then folds the result into
// [-90,+90] and records which output signs must be flipped.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       capture theta into the working angle
//   theta      unsigned integer degrees 0..2047
//   step       high while the sequencer sits in its reduce state
//   z          reduced signed angle (registered, stable until next reduce)
//   neg_c      negate core X to obtain cos
//   neg_s      negate core Y to obtain sin
//   rdy        combinational: working angle is below 360 this cycle, so the
//              decoded z/neg_c/neg_s are being registered at this edge
module cordic_angle_reduce
  import cordic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [ANG_W-1:0]        theta,
  input  logic                    step,
  output logic signed [ANG_W-1:0] z,
  output logic                    neg_c,
  output logic                    neg_s,
  output logic                    rdy
);

  logic [ANG_W-1:0]        ang_reg;
  logic signed [ANG_W-1:0] z_reg;
  logic signed [ANG_W-1:0] z_next;
  logic                    neg_c_reg;
  logic                    neg_c_next;
  logic                    neg_s_reg;
  logic                    neg_s_next;
  logic                    in_range;

  assign in_range = (ang_reg < DEG_360);
  assign rdy      = step && in_range;

  // Quadrant fold. The fourth quadrant uses an 11-bit wrapping subtract,
  // which yields the negative two's-complement angle directly.
  always_comb begin
    z_next     = '0;
    neg_c_next = 1'b0;
    neg_s_next = 1'b0;
    if (ang_reg <= DEG_90) begin
      z_next = $signed(ang_reg);
    end else if (ang_reg <= DEG_180) begin
      z_next     = $signed(DEG_180 - ang_reg);
      neg_c_next = 1'b1;
    end else if (ang_reg <= DEG_270) begin
      z_next     = $signed(ang_reg - DEG_180);
      neg_c_next = 1'b1;
      neg_s_next = 1'b1;
    end else begin
      z_next = $signed(ang_reg - DEG_360);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ang_reg   <= '0;
      z_reg     <= '0;
      neg_c_reg <= 1'b0;
      neg_s_reg <= 1'b0;
    end else if (load) begin
      ang_reg <= theta;
    end else if (step) begin
      if (!in_range) begin
        ang_reg <= ang_reg - DEG_360;
      end else begin
        z_reg     <= z_next;
        neg_c_reg <= neg_c_next;
        neg_s_reg <= neg_s_next;
      end
    end
  end

  assign z     = z_reg;
  assign neg_c = neg_c_reg;
  assign neg_s = neg_s_reg;

endmodule

// File: rtl/cordic_angle_sequencer.sv
// Front/back-end sequencer for a CORDIC rotation core.
// Accepts an integer-degree angle, reduces it into the core's convergence
// range, resets/loads/starts the core, waits for done (with timeout), then
// applies quadrant sign correction and returns cos/sin in Q2.30.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_theta   request handshake, angle in degrees
//   cordic_rst/start         core control
//   cordic_x0/y0/z0          core operands (x0 = 1/K, y0 = 0, z0 = reduced angle)
//   cordic_done/x/y/z        core status and results
//   out_valid/out_ready      result handshake
//   out_cos/out_sin          signed Q2.30 results
//   out_resid                core residual angle passthrough
//   out_err                  core timed out; cos/sin/resid forced to 0
module cordic_angle_sequencer
  import cordic_pkg::*;
#(
  parameter int W       = 32,
  parameter int Z_FRAC  = 0,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ANG_W-1:0] in_theta,
  output logic             cordic_rst,
  output logic             cordic_start,
  output logic [W-1:0]     cordic_x0,
  output logic [W-1:0]     cordic_y0,
  output logic [W-1:0]     cordic_z0,
  input  logic             cordic_done,
  input  logic [W-1:0]     cordic_x,
  input  logic [W-1:0]     cordic_y,
  input  logic [W-1:0]     cordic_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_cos,
  output logic [W-1:0]     out_sin,
  output logic [W-1:0]     out_resid,
  output logic             out_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t state_reg;
  state_t state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_hit;

  logic                    red_rdy;
  logic signed [ANG_W-1:0] red_z;
  logic                    red_neg_c;
  logic                    red_neg_s;
  logic                    in_fire;

  logic [W-1:0] cos_reg;
  logic [W-1:0] sin_reg;
  logic [W-1:0] resid_reg;
  logic         err_reg;

  // Lane 0 carries X/cos, lane 1 carries Y/sin.
  logic [W-1:0] core_val [2];
  logic         neg_flag [2];
  logic [W-1:0] corr_val [2];

  assign in_ready = (state_reg == ST_IDLE) && !rst;
  assign in_fire  = in_ready && in_valid;

  cordic_angle_reduce u_reduce (
    .clk   (clk),
    .rst   (rst),
    .load  (in_fire),
    .theta (in_theta),
    .step  (state_reg == ST_REDUCE),
    .z     (red_z),
    .neg_c (red_neg_c),
    .neg_s (red_neg_s),
    .rdy   (red_rdy)
  );

  // Operands are driven continuously from the registered reduce result, so
  // they are already settled by the time the core leaves reset.
  assign cordic_x0    = W'(X0_GAIN);
  assign cordic_y0    = '0;
  assign cordic_z0    = {{(W-ANG_W){red_z[ANG_W-1]}}, red_z} << Z_FRAC;
  assign cordic_rst   = rst || (state_reg == ST_CRST);
  assign cordic_start = (state_reg == ST_RUN);

  assign core_val[0] = cordic_x;
  assign core_val[1] = cordic_y;
  assign neg_flag[0] = red_neg_c;
  assign neg_flag[1] = red_neg_s;

  // |X|,|Y| never exceed 1.0 in Q2.30, so a wrapping negate cannot overflow.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sign
      assign corr_val[gi] = neg_flag[gi] ? (~core_val[gi] + W'(1)) : core_val[gi];
    end
  endgenerate

  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (in_valid) state_next = ST_REDUCE;
      ST_REDUCE: if (red_rdy) state_next = ST_CRST;
      ST_CRST:   state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_RUN;
      ST_RUN:    if (cordic_done || timeout_hit) state_next = ST_OUT;
      ST_OUT:    if (out_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_LOAD) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // done takes priority over a simultaneous timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cos_reg   <= '0;
      sin_reg   <= '0;
      resid_reg <= '0;
      err_reg   <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      if (cordic_done) begin
        cos_reg   <= corr_val[0];
        sin_reg   <= corr_val[1];
        resid_reg <= cordic_z;
        err_reg   <= 1'b0;
      end else if (timeout_hit) begin
        cos_reg   <= '0;
        sin_reg   <= '0;
        resid_reg <= '0;
        err_reg   <= 1'b1;
      end
    end
  end

  assign out_valid = (state_reg == ST_OUT);
  assign out_cos   = cos_reg;
  assign out_sin   = sin_reg;
  assign out_resid = resid_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Scoreboard bench for cordic_angle_sequencer with a behavioural core that
// returns cos/sin of the reduced angle after a fixed latency.
module tb_cordic_angle_sequencer;

  localparam int W        = 32;
  localparam int TO       = 16;
  localparam int CORE_LAT = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [10:0]   in_theta;
  logic          cordic_rst;
  logic          cordic_start;
  logic [W-1:0]  cordic_x0;
  logic [W-1:0]  cordic_y0;
  logic [W-1:0]  cordic_z0;
  logic          cordic_done;
  logic [W-1:0]  cordic_x;
  logic [W-1:0]  cordic_y;
  logic [W-1:0]  cordic_z;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_cos;
  logic [W-1:0]  out_sin;
  logic [W-1:0]  out_resid;
  logic          out_err;

  logic          stub_done;
  int            core_cnt;

  always #5 clk = ~clk;

  cordic_angle_sequencer #(.W(W), .Z_FRAC(0), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_theta     (in_theta),
    .cordic_rst   (cordic_rst),
    .cordic_start (cordic_start),
    .cordic_x0    (cordic_x0),
    .cordic_y0    (cordic_y0),
    .cordic_z0    (cordic_z0),
    .cordic_done  (cordic_done),
    .cordic_x     (cordic_x),
    .cordic_y     (cordic_y),
    .cordic_z     (cordic_z),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cos      (out_cos),
    .out_sin      (out_sin),
    .out_resid    (out_resid),
    .out_err      (out_err)
  );

  // Behavioural core: cos/sin of z0 (first-quadrant / fourth-quadrant values only).
  function automatic logic [63:0] core_xy(input logic [31:0] z);
    case (z)
      32'd0:        return {32'h40000000, 32'h00000000};
      32'd5:        return {32'h3FC1A749, 32'h0593F5AE};
      32'd45:       return {32'h2D413CCD, 32'h2D413CCD};
      32'd60:       return {32'h20000000, 32'h376CF5D1};
      32'd67:       return {32'h1901BD1F, 32'h3AE98D30};
      32'd90:       return {32'h00000000, 32'h40000000};
      32'hFFFFFFC4: return {32'h20000000, 32'hC8930A2F};
      default:      return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cordic_rst) core_cnt <= 0;
    else if (cordic_start && core_cnt < 1000) core_cnt <= core_cnt + 1;
  end

  assign cordic_done = !stub_done && (core_cnt >= CORE_LAT);
  assign cordic_x    = core_xy(cordic_z0)[63:32];
  assign cordic_y    = core_xy(cordic_z0)[31:0];
  assign cordic_z    = {24'hA5A5A5, cordic_z0[7:0]};

  typedef struct {
    logic [31:0] c;
    logic [31:0] s;
    logic [31:0] r;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_tol(input string nm, input logic [31:0] act, input logic [31:0] req);
    int d;
    d = $signed(act - req);
    total++;
    if ($isunknown(act) || d > 64 || d < -64) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (+/-64)", nm, act, req);
    end
  endtask

  // Monitor: pop and compare whenever a result is accepted.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=%h/%h required=none", out_cos, out_sin);
      end else begin
        e = sb.pop_front();
        chk_tol("cos", out_cos, e.c);
        chk_tol("sin", out_sin, e.s);
        chk("resid", out_resid, e.r);
        chk("err", {31'd0, out_err}, {31'd0, e.e});
        $display("txn cos=%h sin=%h resid=%h err=%0d", out_cos, out_sin, out_resid, out_err);
      end
    end
  end

  task automatic send(input logic [10:0] th, input logic [31:0] ec, input logic [31:0] es,
                      input logic [31:0] er, input logic ee, input logic [31:0] ez,
                      input int ered, input int elat, input int stall);
    int n;
    bit ir_ok;
    bit stable;
    logic [31:0] hc, hs;
    @(negedge clk);
    if (stall > 0) out_ready = 1'b0;
    chk($sformatf("in_ready_idle[%0d]", th), {31'd0, in_ready}, 32'd1);
    in_theta = th;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{c: ec, s: es, r: er, e: ee});
    #1 in_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cordic_rst) break;
      n++;
    end
    chk($sformatf("reduce_cycles[%0d]", th), n, ered);
    chk($sformatf("z0[%0d]", th), cordic_z0, ez);
    chk($sformatf("in_ready_busy[%0d]", th), {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk($sformatf("crst_width[%0d]", th), {31'd0, cordic_rst}, 32'd0);
    chk($sformatf("load_start[%0d]", th), {31'd0, cordic_start}, 32'd0);
    @(negedge clk);
    chk($sformatf("run_start[%0d]", th), {31'd0, cordic_start}, 32'd1);
    n = 0;
    ir_ok = 1'b1;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
      if (in_ready) ir_ok = 1'b0;
    end
    chk($sformatf("latency[%0d]", th), n, elat);
    if (stall > 0) begin
      hc = out_cos;
      hs = out_sin;
      stable = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        if (out_cos !== hc || out_sin !== hs || !out_valid || in_ready) stable = 1'b0;
      end
      chk($sformatf("stall_stable[%0d]", th), {31'd0, stable}, 32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("valid_drop[%0d]", th), {31'd0, out_valid}, 32'd0);
    chk($sformatf("ready_back[%0d]", th), {31'd0, in_ready}, 32'd1);
    chk($sformatf("ready_low_in_flight[%0d]", th), {31'd0, ir_ok}, 32'd1);
  endtask

  typedef struct {
    logic [10:0] th;
    logic [31:0] c;
    logic [31:0] s;
    logic [31:0] r;
    logic [31:0] z;
    int          red;
  } vec_t;

  vec_t vecs[10] = '{
    '{11'd0,    32'h40000000, 32'h00000000, 32'hA5A5A500, 32'h00000000, 1},
    '{11'd120,  32'hE0000000, 32'h376CF5D1, 32'hA5A5A53C, 32'h0000003C, 1},
    '{11'd225,  32'hD2BEC333, 32'hD2BEC333, 32'hA5A5A52D, 32'h0000002D, 1},
    '{11'd300,  32'h20000000, 32'hC8930A2F, 32'hA5A5A5C4, 32'hFFFFFFC4, 1},
    '{11'd360,  32'h40000000, 32'h00000000, 32'hA5A5A500, 32'h00000000, 2},
    '{11'd725,  32'h3FC1A749, 32'h0593F5AE, 32'hA5A5A505, 32'h00000005, 3},
    '{11'd90,   32'h00000000, 32'h40000000, 32'hA5A5A55A, 32'h0000005A, 1},
    '{11'd180,  32'hC0000000, 32'h00000000, 32'hA5A5A500, 32'h00000000, 1},
    '{11'd270,  32'h00000000, 32'hC0000000, 32'hA5A5A55A, 32'h0000005A, 1},
    '{11'd2047, 32'hE6FE42E1, 32'hC51672D0, 32'hA5A5A543, 32'h00000043, 6}
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit seen;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_theta  = '0;
    out_ready = 1'b1;
    stub_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},     32'd0);
    chk("rst_out_valid", {31'd0, out_valid},    32'd0);
    chk("rst_crst",      {31'd0, cordic_rst},   32'd1);
    chk("rst_start",     {31'd0, cordic_start}, 32'd0);
    chk("rst_x0",        cordic_x0,             32'h26DD3B6A);
    chk("rst_y0",        cordic_y0,             32'h0);
    chk("rst_z0",        cordic_z0,             32'h0);
    chk("rst_cos",       out_cos,               32'h0);
    chk("rst_err",       {31'd0, out_err},      32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      send(vecs[i].th, vecs[i].c, vecs[i].s, vecs[i].r, 1'b0, vecs[i].z,
           vecs[i].red, CORE_LAT + 1, 0);

    // Core never finishes: timeout path.
    stub_done = 1'b1;
    send(11'd0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1, TO, 0);
    stub_done = 1'b0;

    // Back-pressure on the result.
    send(11'd120, 32'hE0000000, 32'h376CF5D1, 32'hA5A5A53C, 1'b0, 32'h3C, 1, CORE_LAT + 1, 20);

    // Reset in the middle of RUN: result must be dropped.
    @(negedge clk);
    in_theta = 11'd45;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!cordic_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_run", {31'd0, cordic_start}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_start", {31'd0, cordic_start}, 32'd0);
    chk("abort_valid", {31'd0, out_valid},    32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen}, 32'd0);

    // Normal operation after the abort.
    send(11'd300, 32'h20000000, 32'hC8930A2F, 32'hA5A5A5C4, 1'b0, 32'hFFFFFFC4, 1, CORE_LAT + 1, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
